hififo_tpc_fifo: RTL and testbench

//  User-facing end of the to-PC (tpc) channel of hififo_pcie: sinks the tpc_data/tpc_write/tpc_ready stream

---
 rtl/hififo_tpc_fifo_pkg.sv | 11 +
 rtl/hififo_tpc_fifo_ram_sdp.sv | 27 ++
 rtl/hififo_tpc_fifo.sv | 82 ++++++++
 tb/tb_hififo_tpc_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hififo_tpc_fifo_pkg.sv
// hififo_tpc_fifo_pkg: shared widths and default sizing for the to-PC FIFO channel.
//   DATA_W    payload width of one FIFO word
//   ABITS_DEF default log2 FIFO depth
//   SLACK_DEF default free entries guaranteed while tpc_ready=1
//   TOTAL_W   width of the accepted-word counter
package hififo_tpc_fifo_pkg;
    localparam int DATA_W    = 64;
    localparam int ABITS_DEF = 9;
    localparam int SLACK_DEF = 8;
    localparam int TOTAL_W   = 32;
endpackage

// File: rtl/hififo_tpc_fifo_ram_sdp.sv
// hififo_ram_sdp: simple dual-port RAM, one write port and one registered read port.
//   clock   single clock
//   wr_en   write strobe, wr_addr/wr_data written on the rising edge
//   rd_en   read strobe, rd_data updated on the rising edge from rd_addr
//   rd_data registered read data, holds its value while rd_en=0
module hififo_ram_sdp
    import hififo_tpc_fifo_pkg::*;
#(
    parameter int ABITS = ABITS_DEF
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ABITS-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ABITS-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ABITS];
    logic [DATA_W-1:0] rd_data_q;
    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end
    assign rd_data = rd_data_q;
endmodule

// File: rtl/hififo_tpc_fifo.sv
// hififo_tpc_fifo: user-side to-PC FIFO feeding the DMA write engine with a fixed-latency pop port.
//   clock/reset  single clock, synchronous active-high reset
//   tpc_data/tpc_write/tpc_ready  user push stream; tpc_ready is advisory (>= SLACK entries free)
//   dma_read/dma_data/dma_valid   pop port; data valid the cycle after dma_read
//   dma_count   words held, from registered pointers
//   word_total  words accepted since reset (wraps)
//   overflow/underflow  sticky error flags for dropped pushes and ignored pops
module hififo_tpc_fifo
    import hififo_tpc_fifo_pkg::*;
#(
    parameter int ABITS = ABITS_DEF,
    parameter int SLACK = SLACK_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  tpc_data,
    input  logic               tpc_write,
    output logic               tpc_ready,
    input  logic               dma_read,
    output logic [DATA_W-1:0]  dma_data,
    output logic               dma_valid,
    output logic [ABITS:0]     dma_count,
    output logic [TOTAL_W-1:0] word_total,
    output logic               overflow,
    output logic               underflow
);
    localparam logic [ABITS:0] DEPTH = (ABITS+1)'(1) << ABITS;
    logic [ABITS:0] wptr_q, wptr_d, rptr_q, rptr_d, fill, fill_next;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic ready_q, ready_d, valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic full, empty, push, pop;
    // Pointers carry one extra bit so full and empty stay distinct across wrap.
    always_comb begin
        fill      = wptr_q - rptr_q;
        full      = fill == DEPTH;
        empty     = fill == '0;
        push      = tpc_write && !full;
        pop       = dma_read && !empty;
        wptr_d    = wptr_q + (ABITS+1)'(push);
        rptr_d    = rptr_q + (ABITS+1)'(pop);
        fill_next = wptr_d - rptr_d;
        ready_d   = (DEPTH - fill_next) >= (ABITS+1)'(SLACK);
        valid_d   = pop;
        total_d   = total_q + TOTAL_W'(push);
        ovf_d     = ovf_q || (tpc_write && full);
        unf_d     = unf_q || (dma_read && empty);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            total_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            total_q <= total_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    hififo_ram_sdp #(.ABITS(ABITS)) u_ram (
        .clock   (clock),
        .wr_en   (push && !reset),
        .wr_addr (wptr_q[ABITS-1:0]),
        .wr_data (tpc_data),
        .rd_en   (pop),
        .rd_addr (rptr_q[ABITS-1:0]),
        .rd_data (dma_data)
    );
    assign tpc_ready  = ready_q;
    assign dma_valid  = valid_q;
    assign dma_count  = fill;
    assign word_total = total_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule

// File: tb/tb_hififo_tpc_fifo.sv
// tb_hififo_tpc_fifo: self-checking bench for hififo_tpc_fifo with a queue scoreboard.
module tb_hififo_tpc_fifo;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] tpc_data = '0;
    logic        tpc_write = 1'b0;
    logic        tpc_ready;
    logic        dma_read = 1'b0;
    logic [63:0] dma_data;
    logic        dma_valid;
    logic [4:0]  dma_count;
    logic [31:0] word_total;
    logic        overflow, underflow;

    always #5 clock = ~clock;

    hififo_tpc_fifo #(.ABITS(4), .SLACK(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .tpc_data   (tpc_data),
        .tpc_write  (tpc_write),
        .tpc_ready  (tpc_ready),
        .dma_read   (dma_read),
        .dma_data   (dma_data),
        .dma_valid  (dma_valid),
        .dma_count  (dma_count),
        .word_total (word_total),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    int total = 0;
    int bad = 0;

    logic [63:0] mq[$];
    logic [63:0] eq[$];
    logic        m_valid = 1'b0, m_ready = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [31:0] m_total = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: a plain queue of held words; popped words go to eq
    // and are compared against dma_data when the DUT presents them.
    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            eq.delete();
            m_valid = 1'b0;
            m_ready = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_total = '0;
        end else begin
            automatic bit was_full = mq.size() == 16;
            automatic bit was_empty = mq.size() == 0;
            m_valid = dma_read && !was_empty;
            if (m_valid) eq.push_back(mq.pop_front());
            if (dma_read && was_empty) m_unf = 1'b1;
            if (tpc_write && was_full) m_ovf = 1'b1;
            if (tpc_write && !was_full) begin
                mq.push_back(tpc_data);
                m_total = m_total + 1;
            end
            m_ready = (16 - mq.size()) >= 4;
        end
    end

    task automatic step(input logic w, input logic [63:0] d, input logic r, input logic rs = 1'b0);
        tpc_write = w;
        tpc_data = d;
        dma_read = r;
        reset = rs;
        @(posedge clock);
        @(negedge clock);
        chk("count", 64'(dma_count), 64'(mq.size()));
        chk("valid", 64'(dma_valid), 64'(m_valid));
        if (m_valid && eq.size() > 0) chk("data", dma_data, eq.pop_front());
        chk("ready", 64'(tpc_ready), 64'(m_ready));
        chk("total", 64'(word_total), 64'(m_total));
        chk("ovf", 64'(overflow), 64'(m_ovf));
        chk("unf", 64'(underflow), 64'(m_unf));
    endtask

    initial begin
        logic d1, d2;
        int n;
        // 1: reset state, fill 16, drain 16 in order
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_count", 64'(dma_count), 0);
        chk("rst_ready", 64'(tpc_ready), 0);
        chk("rst_valid", 64'(dma_valid), 0);
        for (int i = 0; i < 16; i++) step(1, 64'h1000 + 64'(i), 0);
        chk("t1_full", 64'(dma_count), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1);
            chk("t1_data", dma_data, 64'h1000 + 64'(i));
            chk("t1_valid", 64'(dma_valid), 1);
        end
        step(0, 0, 0);
        chk("t1_empty", 64'(dma_count), 0);
        chk("t1_total", 64'(word_total), 16);
        chk("t1_flags", {62'b0, overflow, underflow}, 0);
        // 2: ready threshold and overflow
        step(0, 0, 0, 1);
        for (int i = 0; i < 12; i++) step(1, 64'h2000 + 64'(i), 0);
        chk("t2_ready12", 64'(tpc_ready), 1);
        step(1, 64'h200c, 0);
        chk("t2_ready13", 64'(tpc_ready), 0);
        for (int i = 13; i < 16; i++) step(1, 64'h2000 + 64'(i), 0);
        chk("t2_ovf_pre", 64'(overflow), 0);
        step(1, 64'hdead, 0);
        chk("t2_ovf", 64'(overflow), 1);
        chk("t2_count", 64'(dma_count), 16);
        step(0, 0, 0);
        chk("t2_ovf_sticky", 64'(overflow), 1);
        chk("t2_total", 64'(word_total), 16);
        // 3: empty pop with same-cycle push
        step(0, 0, 0, 1);
        step(1, 64'haa, 1);
        chk("t3_unf", 64'(underflow), 1);
        chk("t3_valid", 64'(dma_valid), 0);
        step(0, 0, 1);
        chk("t3_data", dma_data, 64'haa);
        chk("t3_valid2", 64'(dma_valid), 1);
        // 4: steady stream at fill 3
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 64'h3000 + 64'(i), 0);
        for (int i = 0; i < 100; i++) begin
            step(1, {$urandom, $urandom}, 1);
            chk("t4_count", 64'(dma_count), 3);
        end
        chk("t4_total", 64'(word_total), 103);
        // 5: reset mid-stream
        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 64'h4000 + 64'(i), 0);
        step(0, 0, 1);
        step(0, 0, 1, 1);
        chk("t5_valid", 64'(dma_valid), 0);
        chk("t5_count", 64'(dma_count), 0);
        chk("t5_ready0", 64'(tpc_ready), 0);
        step(0, 0, 0);
        chk("t5_ready1", 64'(tpc_ready), 1);
        step(1, 64'h55, 0);
        step(0, 0, 1);
        chk("t5_data", dma_data, 64'h55);
        // 6: loopback with 2-cycle ready-to-write latency and random pops
        step(0, 0, 0, 1);
        d1 = 1'b0;
        d2 = 1'b0;
        n = 0;
        while (m_total < 10000 && n < 40000) begin
            step(d2, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
            d2 = d1;
            d1 = tpc_ready;
            n++;
        end
        chk("t6_words", 64'(word_total), 10000);
        n = 0;
        while (mq.size() > 0 && n < 100) begin
            step(0, 0, 1);
            n++;
        end
        step(0, 0, 0);
        chk("t6_drained", 64'(dma_count), 0);
        chk("t6_ovf", 64'(overflow), 0);
        chk("t6_sb_empty", 64'(eq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
